// File: rtl/dwb_pkg.sv
// Shared widths, default depth and FSM state encoding for the posted-write buffer.
package dwb_pkg;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_READ  = 2'd2,
    S_RDONE = 2'd3
  } state_e;
endpackage

// File: rtl/dwb_entry_cam.sv
// Posted-write entry storage: FIFO pointers, youngest-match read lookup and
// coalescing compare against entries that are not already on their way to memory.
module dwb_entry_cam
  import dwb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic              head_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CW-1:0]     count,
  output logic              wr_match,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data
);
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]     idx, match_idx;
  logic [CW-1:0]     count_q, count_d;

  assign count     = count_q;
  assign head_addr = addr_q[head_q];
  // A coalesce into the head on the launch edge must reach memory with the new data.
  assign head_data = (wr_en && wr_match && match_idx == head_q) ? wr_data : data_q[head_q];

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    rd_hit    = 1'b0;
    rd_data   = '0;
    wr_match  = 1'b0;
    match_idx = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && addr_q[idx] == rd_addr) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
      if (valid_q[idx] && addr_q[idx] == wr_addr && !(head_busy && idx == head_q)) begin
        wr_match  = 1'b1;
        match_idx = idx;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
      count_d         = count_d - CW'(1);
    end
    if (wr_en) begin
      if (wr_match) begin
        data_d[match_idx] = wr_data;
      end else begin
        valid_d[tail_q] = 1'b1;
        addr_d[tail_q]  = wr_addr;
        data_d[tail_q]  = wr_data;
        tail_d          = tail_q + PW'(1);
        count_d         = count_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/data_write_buffer.sv
// Posted write buffer between data cache and data memory with read forwarding,
// coalescing and read-miss priority over drains that have not started.
//   state   | meaning
//   S_IDLE  | no memory request outstanding; pick read miss first, else drain head
//   S_DRAIN | head entry being written to memory
//   S_READ  | cache read miss being fetched from memory
//   S_RDONE | latched read data presented to the cache for one cycle
module data_write_buffer
  import dwb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              C_READ,
  input  logic              C_WRITE,
  input  logic [ADDR_W-1:0] C_ADDRESS,
  input  logic [DATA_W-1:0] C_WRITEDATA,
  output logic [DATA_W-1:0] C_READDATA,
  output logic              C_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              m_read_q, m_read_d, m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, rdata_q, rdata_d;
  logic              seen_q, seen_d;

  logic [CW-1:0]     count;
  logic              full, empty, wr_match, rd_hit, rd_miss, head_busy, wr_en, pop, mem_done;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, rd_data;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign rd_miss   = C_READ && !rd_hit;
  assign head_busy = (state_q == S_DRAIN);
  // Completion needs busywait to have been seen high for this request first.
  assign mem_done  = seen_q && !M_BUSYWAIT;
  assign pop       = (state_q == S_DRAIN) && mem_done;
  assign wr_en     = C_WRITE && !C_READ && (wr_match || !full || pop);

  dwb_entry_cam #(.DEPTH(DEPTH)) u_cam (
    .clk       (CLK),
    .rst_n     (RESET),
    .wr_en     (wr_en),
    .wr_addr   (C_ADDRESS),
    .wr_data   (C_WRITEDATA),
    .pop       (pop),
    .head_busy (head_busy),
    .rd_addr   (C_ADDRESS),
    .count     (count),
    .wr_match  (wr_match),
    .head_addr (head_addr),
    .head_data (head_data),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data)
  );

  assign M_READ      = m_read_q;
  assign M_WRITE     = m_write_q;
  assign M_ADDRESS   = m_addr_q;
  assign M_WRITEDATA = m_wdata_q;

  always_comb begin
    C_BUSYWAIT = 1'b0;
    C_READDATA = '0;
    if (!RESET) begin
      C_BUSYWAIT = 1'b0;
    end else if (state_q == S_RDONE) begin
      C_READDATA = rdata_q;
    end else if (C_READ) begin
      C_BUSYWAIT = !rd_hit;
      C_READDATA = rd_hit ? rd_data : '0;
    end else if (C_WRITE) begin
      C_BUSYWAIT = full && !wr_match && !pop;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    seen_d    = seen_q;
    case (state_q)
      S_IDLE: begin
        seen_d = 1'b0;
        if (rd_miss) begin
          state_d  = S_READ;
          m_read_d = 1'b1;
          m_addr_d = C_ADDRESS;
        end else if (!empty) begin
          state_d   = S_DRAIN;
          m_write_d = 1'b1;
          m_addr_d  = head_addr;
          m_wdata_d = head_data;
        end
      end
      S_DRAIN, S_READ: begin
        if (M_BUSYWAIT) seen_d = 1'b1;
        if (mem_done) begin
          state_d   = (state_q == S_READ) ? S_RDONE : S_IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          m_addr_d  = '0;
          m_wdata_d = '0;
          seen_d    = 1'b0;
          if (state_q == S_READ) rdata_d = M_READDATA;
        end
      end
      S_RDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      seen_q    <= seen_d;
    end
  end
endmodule

// File: doc/data_write_buffer.md
DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of posted-write entries (power of two, 2..8).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports C_READ, C_WRITE  in  1 each  block read / write-back request from data cache.
REQ-005 SHALL have ports C_ADDRESS  in  6  block address; C_WRITEDATA  in  32  write-back block.
REQ-006 SHALL have ports C_READDATA  out  32  read block; C_BUSYWAIT  out  1  stall to data cache.
REQ-007 SHALL have ports M_READ, M_WRITE  out  1 each  requests to data memory.
REQ-008 SHALL have ports M_ADDRESS  out  6; M_WRITEDATA  out  32; M_READDATA  in  32; M_BUSYWAIT  in  1.

Function
REQ-009 SHALL hold a FIFO of DEPTH entries {valid, addr[5:0], data[31:0]}, head, tail and count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-010 SHALL treat a memory transaction as complete on the first rising edge where M_BUSYWAIT=0 after M_BUSYWAIT=1 was sampled for that request; M_READ/M_WRITE, M_ADDRESS, M_WRITEDATA held stable until then and deasserted on that edge.
REQ-011 SHALL accept C_WRITE with C_BUSYWAIT=0 (posted, zero wait) when not full, enqueueing at the same edge.
REQ-012 SHALL, on C_WRITE whose address matches a valid entry not currently in flight to memory, overwrite that entry's data in place without allocating (coalescing).
REQ-013 SHALL, on C_WRITE with buffer full and no coalescing match, drive C_BUSYWAIT=1 combinationally until a slot frees; enqueue at the edge the head pops (simultaneous pop and push keeps count = DEPTH).
REQ-014 SHALL, on C_READ matching any valid entry (including in-flight), return youngest matching data on C_READDATA combinationally with C_BUSYWAIT=0 (forward hit, no memory access).
REQ-015 SHALL, on C_READ miss, drive C_BUSYWAIT=1 and issue M_READ ahead of any not-yet-started drain; an already in-flight drain write completes first.
REQ-016 SHALL implement FSM IDLE, DRAIN, READ, RDONE: IDLE->READ on C_READ miss; IDLE->DRAIN when count>0 and no read miss; DRAIN->IDLE on completion (pop head, count-1); READ->RDONE on completion (latch M_READDATA); RDONE->IDLE after one cycle.
REQ-017 SHALL, in RDONE, drive C_READDATA from the latched register and C_BUSYWAIT=0 for exactly one cycle.
REQ-018 SHALL ignore C_WRITE when C_READ and C_WRITE are asserted together (read wins); this is illegal stimulus.
REQ-019 SHALL never assert M_READ and M_WRITE simultaneously.
REQ-020 SHALL, when idle with count=0, hold M_READ=M_WRITE=0 and C_READDATA=0.

Reset
REQ-021 SHALL, while RESET=0, immediately force C_BUSYWAIT=0, C_READDATA=0, M_READ=0, M_WRITE=0, M_ADDRESS=0, M_WRITEDATA=0, state=IDLE, count/head/tail=0, all valid=0.
REQ-022 SHALL discard all pending and in-flight writes on reset mid-operation; no memory request issued before first rising edge after RESET returns to 1.

Structure
REQ-023 SHALL place ADDR_W=6, DATA_W=32, DEPTH default and the FSM state enum in shared package dwb_pkg.
REQ-024 SHALL factor entry storage, youngest-match lookup and coalescing compare into one sub-module dwb_entry_cam; FSM and memory handshake remain in the top.

Verification
REQ-025 SHALL cover: 3 writes to addr 0x01,0x02,0x03 back-to-back -> C_BUSYWAIT stays 0, memory sees three M_WRITE in order with matching data.
REQ-026 SHALL cover: 5 writes to distinct addresses with DEPTH=4 and 5-cycle memory -> fifth write stalls until first drain completes; count never exceeds 4.
REQ-027 SHALL cover: write 0xDEADBEEF to 0x10 then immediate read 0x10 -> C_READDATA=0xDEADBEEF same cycle, no M_READ issued.
REQ-028 SHALL cover: two writes to 0x05 (0x11111111 then 0x22222222) before drain -> one M_WRITE of 0x22222222.
REQ-029 SHALL cover: 2 pending writes, read miss 0x20 -> M_READ issued before pending writes start; C_READDATA valid in RDONE, then writes drain.
REQ-030 SHALL cover: RESET=0 during in-flight M_WRITE -> M_WRITE drops asynchronously, count=0, no further memory traffic.
